dmem_bridge: RTL and testbench

Data-side bus bridge directly downstream of the CPU core's MEM-stage memory port. It converts the core's single-cycle combinational data request (ce/we/addr/sel/wdata) into a request/ready + rvalid handshake bus toward external SRAM/peripherals. Stores are absorbed by a small posted write buffer. Loads stall the core until read data returns. The stall output feeds the core's pipeline control.

---
 rtl/dmem_bridge.sv | 137 +++++++++++++
 tb/tb_dmem_bridge.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bridge.sv
// dmem_bridge: MEM-stage data port to request/ready bus bridge with blocking loads.
// Define DMEM_WBUF_EN for the posted write buffer; without it, stores block until bus_ready.
module dmem_bridge #(
    parameter int WBUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce,
    input  logic        mem_we,
    input  logic [31:0] mem_maddr,
    input  logic [3:0]  mem_msel,
    input  logic [31:0] mem_mdata,
    output logic [31:0] mdata_mem,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);
    typedef enum logic [2:0] {IDLE, DRAIN, RD_REQ, RD_WAIT, RD_DONE} state_t;
    state_t state_q, state_d;
    logic [31:0] raddr_q, raddr_d, rdata_q, rdata_d;
    logic [3:0] rsel_q, rsel_d;
    logic load, store, wr_act, rd_act, wr_stall, has_wr, drained;
    logic [31:0] waddr, wdata;
    logic [3:0] wsel;

    assign load = mem_ce & ~mem_we;
    assign store = mem_ce & mem_we;
    assign rd_act = state_q == RD_REQ;

`ifdef DMEM_WBUF_EN
    localparam int AW = $clog2(WBUF_DEPTH);
    logic [31:0] fa_q [WBUF_DEPTH];
    logic [31:0] fd_q [WBUF_DEPTH];
    logic [3:0] fs_q [WBUF_DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0] cnt_q, cnt_d;
    logic full, push, pop;

    assign full = cnt_q == (AW+1)'(WBUF_DEPTH);
    assign has_wr = cnt_q != '0;
    assign push = store & ~full;
    assign wr_act = has_wr & (state_q == IDLE | state_q == DRAIN);
    assign pop = wr_act & bus_ready;
    assign wr_stall = store & full;
    assign drained = cnt_d == '0;
    assign waddr = fa_q[rp_q];
    assign wsel = fs_q[rp_q];
    assign wdata = fd_q[rp_q];

    always_comb begin
        wp_d = push ? wp_q + 1'b1 : wp_q;
        rp_d = pop ? rp_q + 1'b1 : rp_q;
        cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q <= '0;
            rp_q <= '0;
            cnt_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Payload storage needs no reset: entries are only read while counted.
    always_ff @(posedge clk) begin
        if (push) begin
            fa_q[wp_q] <= mem_maddr;
            fs_q[wp_q] <= mem_msel;
            fd_q[wp_q] <= mem_mdata;
        end
    end
`else
    logic unused_depth;
    assign unused_depth = WBUF_DEPTH[0];
    assign has_wr = 1'b0;
    assign drained = 1'b1;
    assign wr_act = store & (state_q == IDLE);
    assign wr_stall = wr_act & ~bus_ready;
    assign waddr = mem_maddr;
    assign wsel = mem_msel;
    assign wdata = mem_mdata;
`endif

    assign stall = state_q == RD_DONE ? 1'b0 :
                   (state_q == IDLE & load) | state_q == DRAIN | rd_act | state_q == RD_WAIT | wr_stall;
    assign bus_req = wr_act | rd_act;
    assign bus_wr = wr_act;
    assign bus_addr = wr_act ? waddr : rd_act ? raddr_q : '0;
    assign bus_sel = wr_act ? wsel : rd_act ? rsel_q : '0;
    assign bus_wdata = wr_act ? wdata : '0;
    assign mdata_mem = rdata_q;

    always_comb begin
        state_d = state_q;
        raddr_d = raddr_q;
        rsel_d = rsel_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (load) begin
                raddr_d = mem_maddr;
                rsel_d = mem_msel;
                state_d = has_wr ? DRAIN : RD_REQ;
            end
            DRAIN: state_d = drained ? RD_REQ : DRAIN;
            RD_REQ: state_d = bus_ready ? RD_WAIT : RD_REQ;
            RD_WAIT: if (bus_rvalid) begin
                rdata_d = bus_rdata;
                state_d = RD_DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            raddr_q <= '0;
            rsel_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            raddr_q <= raddr_d;
            rsel_q <= rsel_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: scoreboard bench for dmem_bridge; expected bus writes, bus reads and
// load results are queued when driven and popped when the bus or core observes them.
module tb_dmem_bridge;
    logic clk = 1'b0;
    logic rst;
    logic mem_ce, mem_we;
    logic [31:0] mem_maddr, mem_mdata;
    logic [3:0] mem_msel;
    logic [31:0] mdata_mem;
    logic stall, bus_req, bus_wr;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0] bus_sel;
    logic bus_ready, bus_rvalid;
    logic [31:0] bus_rdata;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] data;
    } wr_t;

`ifdef DMEM_WBUF_EN
    localparam int SL_STALLS = 4;
`else
    localparam int SL_STALLS = 3;
`endif

    wr_t wq[$];
    logic [31:0] ldq[$];
    logic [31:0] rq[$];
    logic [31:0] mem [logic [31:0]];
    int n_chk = 0;
    int n_err = 0;
    int n_rd = 0;
    logic auto_rv, rv_pend, ld_done;
    logic [31:0] rv_addr;
    logic s_stall, s_req, s_wr;
    logic [31:0] s_mdata, s_addr, s_wdata;
    logic [3:0] s_sel;

    always #5 clk = ~clk;

    dmem_bridge #(.WBUF_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_maddr(mem_maddr), .mem_msel(mem_msel), .mem_mdata(mem_mdata),
        .mdata_mem(mdata_mem), .stall(stall),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_sel(bus_sel), .bus_wdata(bus_wdata),
        .bus_ready(bus_ready), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: sample at negedge, score bus/core events, then answer accepted reads after the edge.
    task automatic step();
        wr_t e;
        logic [31:0] v;
        @(negedge clk);
        s_stall = stall;
        s_req = bus_req;
        s_wr = bus_wr;
        s_addr = bus_addr;
        s_sel = bus_sel;
        s_wdata = bus_wdata;
        s_mdata = mdata_mem;
        rv_pend = 1'b0;
        if (rst && bus_req && bus_ready && bus_wr) begin
            check("wr_expected", 32'(wq.size() != 0), 32'd1);
            if (wq.size() != 0) begin
                e = wq.pop_front();
                check("wr_addr", bus_addr, e.addr);
                check("wr_sel", 32'(bus_sel), 32'(e.sel));
                check("wr_data", bus_wdata, e.data);
            end
            v = mem.exists(bus_addr) ? mem[bus_addr] : 32'h0;
            for (int b = 0; b < 4; b++) if (bus_sel[b]) v[8*b +: 8] = bus_wdata[8*b +: 8];
            mem[bus_addr] = v;
        end
        if (rst && bus_req && bus_ready && !bus_wr) begin
            n_rd++;
            check("rd_after_drain", 32'(wq.size()), 32'd0);
            check("rd_expected", 32'(rq.size() != 0), 32'd1);
            if (rq.size() != 0) check("rd_addr", bus_addr, rq.pop_front());
            rv_pend = auto_rv;
            rv_addr = bus_addr;
        end
        if (rst && mem_ce && !mem_we && !stall) begin
            ld_done = 1'b1;
            check("ld_expected", 32'(ldq.size() != 0), 32'd1);
            if (ldq.size() != 0) check("ld_data", mdata_mem, ldq.pop_front());
        end
        @(posedge clk);
        #1;
        bus_rvalid = rv_pend;
        bus_rdata = rv_pend ? (mem.exists(rv_addr) ? mem[rv_addr] : 32'h0) : 32'h0;
    endtask

    task automatic drive(input logic we, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        wr_t e;
        mem_ce = 1'b1;
        mem_we = we;
        mem_maddr = a;
        mem_msel = s;
        mem_mdata = d;
        e.addr = a;
        e.sel = s;
        e.data = d;
        if (we) wq.push_back(e);
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] exp, output int stalls);
        drive(1'b0, a, 4'hF, 32'h0);
        ldq.push_back(exp);
        rq.push_back(a);
        stalls = 0;
        ld_done = 1'b0;
        for (int i = 0; i < 40 && !ld_done; i++) begin
            step();
            stalls += int'(s_stall);
        end
        check("ld_finished", 32'(ld_done), 32'd1);
        mem_ce = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_stall"}, 32'(s_stall), 32'd0);
        check({tag, "_mdata"}, s_mdata, 32'd0);
        check({tag, "_req"}, 32'(s_req), 32'd0);
        check({tag, "_wr"}, 32'(s_wr), 32'd0);
        check({tag, "_addr"}, s_addr, 32'd0);
        check({tag, "_sel"}, 32'(s_sel), 32'd0);
        check({tag, "_wdata"}, s_wdata, 32'd0);
    endtask

    initial begin
        int st, rd0;
        rst = 1'b0;
        mem_ce = 1'b0;
        mem_we = 1'b0;
        mem_maddr = '0;
        mem_msel = '0;
        mem_mdata = '0;
        bus_ready = 1'b1;
        bus_rvalid = 1'b0;
        bus_rdata = '0;
        auto_rv = 1'b1;
        rv_pend = 1'b0;
        rv_addr = '0;
        ld_done = 1'b0;
        mem[32'h100] = 32'hDEADBEEF;
        mem[32'h40] = 32'hCAFEF00D;
        step();
        step();
        check_idle("rst");
        rst = 1'b1;
        step();
        check_idle("post_rst");

        // Reset while the read is outstanding; a late rvalid must not land.
        auto_rv = 1'b0;
        drive(1'b0, 32'h40, 4'hF, 32'h0);
        rq.push_back(32'h40);
        step();
        check("rw_stall", 32'(s_stall), 32'd1);
        step();
        check("rw_req", 32'(s_req), 32'd1);
        mem_ce = 1'b0;
        rst = 1'b0;
        step();
        check("rw_rst_stall", 32'(s_stall), 32'd0);
        rst = 1'b1;
        auto_rv = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata = 32'h1234;
        step();
        check("rw_idle_stall", 32'(s_stall), 32'd0);
        step();
        check("rw_no_capture", s_mdata, 32'd0);

        rd0 = n_rd;
        do_load(32'h100, 32'hDEADBEEF, st);
        check("ld_stalls", 32'(st), 32'd3);
        step();
        check("ld_hold", s_mdata, 32'hDEADBEEF);
        check("ld_one_read", 32'(n_rd - rd0), 32'd1);

        bus_rvalid = 1'b1;
        bus_rdata = 32'h1234;
        step();
        check("stray_stall", 32'(s_stall), 32'd0);
        check("stray_req", 32'(s_req), 32'd0);
        step();
        check("stray_mdata", s_mdata, 32'hDEADBEEF);

`ifdef DMEM_WBUF_EN
        bus_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(i * 4), 4'hF, 32'h1000 + 32'(i));
            step();
            check("wb_nostall", 32'(s_stall), 32'd0);
        end
        drive(1'b1, 32'h10, 4'hF, 32'h1004);
        step();
        check("wb_full0", 32'(s_stall), 32'd1);
        step();
        check("wb_full1", 32'(s_stall), 32'd1);
        bus_ready = 1'b1;
        step();
        check("wb_pop_cycle", 32'(s_stall), 32'd1);
        bus_ready = 1'b0;
        step();
        check("wb_accept", 32'(s_stall), 32'd0);
        mem_ce = 1'b0;
        bus_ready = 1'b1;
        repeat (6) step();
        check("wb_drained", 32'(wq.size()), 32'd0);
`else
        bus_ready = 1'b0;
        drive(1'b1, 32'h30, 4'h3, 32'hA5A55A5A);
        step();
        check("bs_stall0", 32'(s_stall), 32'd1);
        check("bs_wr", 32'(s_wr), 32'd1);
        step();
        check("bs_stall1", 32'(s_stall), 32'd1);
        bus_ready = 1'b1;
        step();
        check("bs_done", 32'(s_stall), 32'd0);
        check("bs_written", 32'(wq.size()), 32'd0);
        mem_ce = 1'b0;
`endif

        drive(1'b1, 32'h20, 4'hF, 32'h55);
        step();
        check("sl_store_stall", 32'(s_stall), 32'd0);
        do_load(32'h20, 32'h55, st);
        check("sl_stalls", 32'(st), 32'(SL_STALLS));
        step();

        check("end_wq", 32'(wq.size()), 32'd0);
        check("end_ldq", 32'(ldq.size()), 32'd0);
        check("end_rq", 32'(rq.size()), 32'd0);
        check("end_reads", 32'(n_rd), 32'd3);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
